// File: rtl/multi_channel_input_buffer_interface.sv
// rtl/multi_channel_input_buffer_interface.sv - NUM_CH packet streams merged into one packet-buffer write port
// Purpose : per-channel whole-packet FIFOs with admission control, truncation and
//           open-packet repair, drained at packet granularity into a single
//           hold-until-ack packet-buffer write port.
// Config  : `define ARB_PRIORITY_CH0_EN gives channel 0 strict priority in IDLE;
//           undefined means pure round-robin over all channels.
// Ports   : clk_sys, reset_n                      clock, async active-low reset
//           iv_pkt_wr, iv_pkt, iv_pkt_bufid       per-channel ingress words
//           ov_pkt, o_pkt_wr, ov_pkt_bufadd       packet-buffer write port
//           i_pkt_ack                             packet buffer accepted the word
//           ov_grant_ch, ov_state                 arbitration / output FSM status
//           ov_discard_pulse, ov_trunc_pulse      per-channel drop indications
module multi_channel_input_buffer_interface #(
  parameter int NUM_CH        = 4,
  parameter int BUFID_W       = 9,
  parameter int IDX_W         = 7,
  parameter int FIFO_AW       = 7,
  parameter int MAX_PKT_WORDS = 96
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          iv_pkt_wr,
  input  logic [NUM_CH*134-1:0]      iv_pkt,
  input  logic [NUM_CH*BUFID_W-1:0]  iv_pkt_bufid,
  output logic [133:0]               ov_pkt,
  output logic                       o_pkt_wr,
  output logic [BUFID_W+IDX_W-1:0]   ov_pkt_bufadd,
  input  logic                       i_pkt_ack,
  output logic [2:0]                 ov_grant_ch,
  output logic [NUM_CH-1:0]          ov_discard_pulse,
  output logic [NUM_CH-1:0]          ov_trunc_pulse,
  output logic [1:0]                 ov_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EW    = BUFID_W + 134;
  localparam logic [FIFO_AW:0] L_DEPTH    = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] L_MAX      = (FIFO_AW+1)'(MAX_PKT_WORDS);
  localparam logic [FIFO_AW:0] L_BODY_MAX = (FIFO_AW+1)'(MAX_PKT_WORDS - 1);
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b11;
  localparam logic [1:0] T_TAIL = 2'b10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2} state_t;

  // FIFO storage; r_ftail marks entries rewritten as synthetic tails
  logic [EW-1:0]      r_mem   [NUM_CH][DEPTH];
  logic [DEPTH-1:0]   r_ftail [NUM_CH];
  logic [FIFO_AW-1:0] r_wptr  [NUM_CH];
  logic [FIFO_AW-1:0] r_rptr  [NUM_CH];
  logic [FIFO_AW:0]   r_cnt   [NUM_CH];
  logic [FIFO_AW:0]   r_pkts  [NUM_CH];
  logic [FIFO_AW:0]   r_wcnt  [NUM_CH];
  logic [BUFID_W-1:0] r_bufid [NUM_CH];
  logic [NUM_CH-1:0]  r_open;
  logic [NUM_CH-1:0]  r_trunc;

  state_t             r_state;
  logic [CH_W-1:0]    r_gsel;
  logic [CH_W-1:0]    r_rr;
  logic [IDX_W-1:0]   r_idx;

  logic [1:0]         w_typ  [NUM_CH];
  logic [FIFO_AW:0]   w_free [NUM_CH];
  logic [EW-1:0]      w_wdata[NUM_CH];
  logic [NUM_CH-1:0]  w_head, w_admit, w_fix, w_body_ok, w_tail_ok, w_push;
  logic [NUM_CH-1:0]  w_tail_in, w_trunc_ev, w_pop, w_tail_pop, w_elig;
  logic [EW-1:0]      w_rd_entry;
  logic               w_rd_ftail;
  logic [133:0]       w_rd_word;
  logic               w_found;
  logic [CH_W-1:0]    w_next;
  int                 v_j;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_typ[c]      = iv_pkt[c*134+132 +: 2];
      w_free[c]     = L_DEPTH - r_cnt[c];
      w_head[c]     = iv_pkt_wr[c] && (w_typ[c] == T_HEAD);
      // admission reserves room for a worst-case packet
      w_admit[c]    = w_head[c] && (w_free[c] >= L_MAX);
      // a head while a packet is open turns the last stored word into its tail
      w_fix[c]      = w_head[c] && r_open[c];
      w_body_ok[c]  = iv_pkt_wr[c] && (w_typ[c] == T_BODY) && r_open[c] && (r_wcnt[c] < L_BODY_MAX);
      w_tail_ok[c]  = iv_pkt_wr[c] && (w_typ[c] == T_TAIL) && r_open[c];
      w_trunc_ev[c] = iv_pkt_wr[c] && (w_typ[c] == T_BODY) && r_open[c] &&
                      (r_wcnt[c] >= L_BODY_MAX) && !r_trunc[c];
      w_push[c]     = w_admit[c] || w_body_ok[c] || w_tail_ok[c];
      w_tail_in[c]  = w_tail_ok[c] || w_fix[c];
      w_wdata[c]    = {w_head[c] ? iv_pkt_bufid[c*BUFID_W +: BUFID_W] : r_bufid[c],
                       iv_pkt[c*134 +: 134]};
      w_pop[c]      = (r_state == S_SEND) && i_pkt_ack && (r_gsel == CH_W'(c));
      w_tail_pop[c] = w_pop[c] && (ov_pkt[133:132] == T_TAIL);
      w_elig[c]     = (r_pkts[c] != '0);
    end
  end

  assign w_rd_entry = r_mem[r_gsel][r_rptr[r_gsel]];
  assign w_rd_ftail = r_ftail[r_gsel][r_rptr[r_gsel]];
  assign w_rd_word  = w_rd_ftail ? {T_TAIL, w_rd_entry[131:0]} : w_rd_entry[133:0];

  always_ff @(posedge clk_sys) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wptr[c]]   <= w_wdata[c];
        r_ftail[c][r_wptr[c]] <= 1'b0;
      end
      if (w_fix[c]) r_ftail[c][r_wptr[c] - FIFO_AW'(1)] <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_cnt[c]   <= '0;
        r_pkts[c]  <= '0;
        r_wcnt[c]  <= '0;
        r_bufid[c] <= '0;
      end
      r_open           <= '0;
      r_trunc          <= '0;
      ov_discard_pulse <= '0;
      ov_trunc_pulse   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ov_discard_pulse[c] <= w_head[c] && !w_admit[c];
        ov_trunc_pulse[c]   <= w_trunc_ev[c];
        if (w_trunc_ev[c]) r_trunc[c] <= 1'b1;
        if (w_head[c]) begin
          r_open[c]  <= w_admit[c];
          r_trunc[c] <= 1'b0;
          r_wcnt[c]  <= w_admit[c] ? (FIFO_AW+1)'(1) : '0;
          if (w_admit[c]) r_bufid[c] <= iv_pkt_bufid[c*BUFID_W +: BUFID_W];
        end else if (w_tail_ok[c]) begin
          r_open[c] <= 1'b0;
        end else if (w_body_ok[c]) begin
          r_wcnt[c] <= r_wcnt[c] + (FIFO_AW+1)'(1);
        end
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + FIFO_AW'(1);
        if (w_pop[c])  r_rptr[c] <= r_rptr[c] + FIFO_AW'(1);
        r_cnt[c]  <= r_cnt[c] + (FIFO_AW+1)'(w_push[c]) - (FIFO_AW+1)'(w_pop[c]);
        r_pkts[c] <= r_pkts[c] + (FIFO_AW+1)'(w_tail_in[c]) - (FIFO_AW+1)'(w_tail_pop[c]);
      end
    end
  end

  // next grant: upward search starting one past the last grant
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    v_j     = 0;
`ifdef ARB_PRIORITY_CH0_EN
    if (w_elig[0]) w_found = 1'b1;
`endif
    for (int k = 1; k <= NUM_CH; k++) begin
      v_j = int'(r_rr) + k;
      if (v_j >= NUM_CH) v_j = v_j - NUM_CH;
      if (!w_found && w_elig[v_j]) begin
        w_found = 1'b1;
        w_next  = CH_W'(v_j);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_gsel        <= '0;
      r_rr          <= CH_W'(NUM_CH - 1);
      r_idx         <= '0;
      ov_pkt        <= '0;
      o_pkt_wr      <= 1'b0;
      ov_pkt_bufadd <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_gsel  <= w_next;
          r_rr    <= w_next;
          r_idx   <= '0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          ov_pkt        <= w_rd_word;
          ov_pkt_bufadd <= {w_rd_entry[EW-1 -: BUFID_W], r_idx};
          o_pkt_wr      <= 1'b1;
          r_state       <= S_SEND;
        end
        S_SEND: if (i_pkt_ack) begin
          r_idx <= r_idx + IDX_W'(1);
          if (ov_pkt[133:132] == T_TAIL) begin
            o_pkt_wr <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_state  <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ov_state    = r_state;
  assign ov_grant_ch = 3'(r_gsel);

endmodule

// File: tb/tb_multi_channel_input_buffer_interface.sv
// tb/tb_multi_channel_input_buffer_interface.sv - directed self-checking bench for multi_channel_input_buffer_interface
module tb_multi_channel_input_buffer_interface;

  localparam int NCH = 4;
  localparam int BW  = 9;
  localparam int IW  = 7;
  localparam logic [1:0] HD = 2'b01, BD = 2'b11, TL = 2'b10;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [NCH-1:0]     wr;
  logic [133:0]       wd [NCH];
  logic [BW-1:0]      wb [NCH];
  logic [NCH*134-1:0] pkt_bus;
  logic [NCH*BW-1:0]  bid_bus;
  logic [133:0]       opkt;
  logic               o_pkt_wr;
  logic [BW+IW-1:0]   badd;
  logic               ack;
  logic [2:0]         grant;
  logic [NCH-1:0]     disc, trc;
  logic [1:0]         ov_state;

  always_comb begin
    pkt_bus = '0;
    bid_bus = '0;
    for (int c = 0; c < NCH; c++) begin
      pkt_bus[c*134 +: 134] = wd[c];
      bid_bus[c*BW +: BW]   = wb[c];
    end
  end

  multi_channel_input_buffer_interface dut (
    .clk_sys(clk), .reset_n(rstn), .iv_pkt_wr(wr), .iv_pkt(pkt_bus), .iv_pkt_bufid(bid_bus),
    .ov_pkt(opkt), .o_pkt_wr(o_pkt_wr), .ov_pkt_bufadd(badd), .i_pkt_ack(ack),
    .ov_grant_ch(grant), .ov_discard_pulse(disc), .ov_trunc_pulse(trc), .ov_state(ov_state));

  logic [BW+IW-1:0] wa_q[$];
  logic [133:0]     wdq[$];
  int               gq[$];
  int               n_disc[NCH];
  int               n_trunc[NCH];

  always @(negedge clk) if (rstn === 1'b1) begin
    if (ov_state == 2'd2 && o_pkt_wr && ack) begin
      wa_q.push_back(badd);
      wdq.push_back(opkt);
      if (badd[IW-1:0] == '0) gq.push_back(int'(grant));
    end
    for (int c = 0; c < NCH; c++) begin
      n_disc[c]  += int'(disc[c]);
      n_trunc[c] += int'(trc[c]);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [133:0] mkw(input logic [1:0] t, input int c, input int p, input int w);
    return {t, 100'd0, 8'(c), 8'(p), 16'(w)};
  endfunction

  function automatic logic [1:0] typ(input int w, input int n);
    if (w == 0) return HD;
    if (w == n - 1) return TL;
    return BD;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input logic [1:0] t, input int p, input int w, input logic [BW-1:0] b);
    wr[c] = 1'b1;
    wd[c] = mkw(t, c, p, w);
    wb[c] = b;
  endtask

  task automatic send_pkt(input int c, input int p, input int n, input logic [BW-1:0] b);
    for (int w = 0; w < n; w++) begin
      put(c, typ(w, n), p, w, b);
      tick;
    end
    wr = '0;
  endtask

  task automatic clr;
    wa_q.delete();
    wdq.delete();
    gq.delete();
    for (int c = 0; c < NCH; c++) begin
      n_disc[c]  = 0;
      n_trunc[c] = 0;
    end
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (wa_q.size() < n && k < budget) begin
      tick;
      k++;
    end
    repeat (6) tick;
    check(tag, wa_q.size(), n);
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    tick;
    tick;
    rstn = 1'b1;
    tick;
  endtask

  int exp_rr[8];
  int chg;
  int k;
  logic [133:0]     snap_p;
  logic [BW+IW-1:0] snap_a;

  initial begin
    wr  = '0;
    ack = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      wd[c] = '0;
      wb[c] = '0;
    end
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (3) tick;
    check("rst_wr", o_pkt_wr, 0);
    check("rst_state", ov_state, 0);
    check("rst_grant", grant, 0);
    check("rst_bufadd", badd, 0);
    check("rst_pkt", opkt, 0);
    check("rst_pulses", {disc, trc}, 0);
    rstn = 1'b1;
    tick;

    // single packet on channel 1, ack held high
    clr();
    ack = 1'b1;
    send_pkt(1, 0, 4, 9'h05A);
    check("lat_e0_state", ov_state, 0);
    tick;
    check("lat_e1_state", ov_state, 1);
    check("lat_e1_wr", o_pkt_wr, 0);
    tick;
    check("lat_e2_wr", o_pkt_wr, 1);
    check("lat_e2_pkt", opkt, mkw(HD, 1, 0, 0));
    check("lat_e2_addr", badd, 16'h2D00);
    wait_writes("single_cnt", 4, 40);
    for (int i = 0; i < 4; i++) begin
      check("single_addr", (i < wa_q.size()) ? wa_q[i] : 16'hFFFF, 16'h2D00 + 16'(i));
      check("single_data", (i < wdq.size()) ? wdq[i] : '1, mkw(typ(i, 4), 1, 0, i));
    end
    check("single_idle", ov_state, 0);

    // round-robin fairness: all channels load two packets in parallel
    do_reset();
    clr();
    ack = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int w = 0; w < 5; w++) begin
        for (int c = 0; c < NCH; c++) put(c, typ(w, 5), p, w, 9'(c*16 + p));
        tick;
      end
    wr  = '0;
    ack = 1'b1;
    wait_writes("rr_cnt", 40, 400);
`ifdef ARB_PRIORITY_CH0_EN
    exp_rr = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int i = 0; i < 8; i++)
      check("rr_grant", (i < gq.size()) ? gq[i] : -1, exp_rr[i]);
    check("rr_last", (wdq.size() == 40) ? wdq[39] : '1, mkw(TL, 3, 1, 4));

    // ack backpressure mid-packet on channel 3
    clr();
    ack = 1'b0;
    send_pkt(3, 0, 6, 9'h033);
    for (int w = 0; w < 6; w++) begin
      k = 0;
      while (ov_state != 2'd2 && k < 20) begin
        tick;
        k++;
      end
      check("bp_wait", ov_state, 2);
      if (w == 2) begin
        snap_p = opkt;
        snap_a = badd;
        chg = 0;
        repeat (10) begin
          tick;
          if (opkt !== snap_p || badd !== snap_a || o_pkt_wr !== 1'b1) chg++;
        end
        check("bp_hold", chg, 0);
      end
      ack = 1'b1;
      tick;
      ack = 1'b0;
    end
    repeat (4) tick;
    check("bp_cnt", wa_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("bp_addr", (i < wa_q.size()) ? wa_q[i] : 16'hFFFF, {9'h033, 7'(i)});
      check("bp_data", (i < wdq.size()) ? wdq[i] : '1, mkw(typ(i, 6), 3, 0, i));
    end

    // discard: channel 2 holds 40 unsent words, then a new head arrives
    clr();
    ack = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(2, p, 10, 9'(9'h040 + p));
    put(2, HD, 4, 0, 9'h1FF);
    tick;
    wr = '0;
    check("disc_pulse", disc, 4'b0100);
    tick;
    check("disc_pulse_clr", disc, 4'b0000);
    put(2, BD, 4, 1, 9'h1FF);
    tick;
    put(2, TL, 4, 2, 9'h1FF);
    tick;
    wr = '0;
    check("disc_count", n_disc[2], 1);
    ack = 1'b1;
    wait_writes("disc_drain", 40, 400);
    check("disc_last_addr", (wa_q.size() == 40) ? wa_q[39] : 16'hFFFF, {9'h043, 7'd9});
    check("disc_last_data", (wdq.size() == 40) ? wdq[39] : '1, mkw(TL, 2, 3, 9));

    // truncation: 120-word packet on channel 0
    clr();
    ack = 1'b1;
    send_pkt(0, 0, 120, 9'h077);
    wait_writes("trunc_cnt", 96, 400);
    check("trunc_pulse", n_trunc[0], 1);
    check("trunc_tail_addr", (wa_q.size() == 96) ? wa_q[95] : 16'hFFFF, {9'h077, 7'd95});
    check("trunc_tail_data", (wdq.size() == 96) ? wdq[95] : '1, mkw(TL, 0, 0, 119));
    check("trunc_last_body", (wdq.size() == 96) ? wdq[94] : '1, mkw(BD, 0, 0, 94));

    // reset mid-packet
    clr();
    ack = 1'b0;
    send_pkt(1, 0, 4, 9'h011);
    put(2, HD, 0, 0, 9'h022);
    tick;
    put(2, BD, 0, 1, 9'h022);
    tick;
    wr = '0;
    k = 0;
    while (ov_state != 2'd2 && k < 20) begin
      tick;
      k++;
    end
    check("mid_send", o_pkt_wr, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_wr", o_pkt_wr, 0);
    check("mid_rst_state", ov_state, 0);
    tick;
    tick;
    rstn = 1'b1;
    tick;
    clr();
    ack = 1'b1;
    put(2, BD, 0, 2, 9'h022);
    tick;
    put(2, TL, 0, 3, 9'h022);
    tick;
    wr = '0;
    send_pkt(1, 1, 3, 9'h044);
    wait_writes("post_rst_cnt", 3, 60);
    check("post_rst_first", (wa_q.size() > 0) ? wa_q[0] : 16'hFFFF, {9'h044, 7'd0});
    check("post_rst_last", (wa_q.size() > 2) ? wa_q[2] : 16'hFFFF, {9'h044, 7'd2});
    check("post_rst_head", (wdq.size() > 0) ? wdq[0] : '1, mkw(HD, 1, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
